tone_sequencer: RTL and testbench

Plays a stored melody on the organ's tone generator without the operator touching the switches. It holds up to 16 note entries, each a note code plus a duration in beats. It steps through them on a fixed beat timebase derived from the 50 MHz clock. It drives the tone generator's 3-bit note select and a tone gate, and inserts a short silent gap between notes so that repeated notes are audible as separate notes.

---
 rtl/tone_sequencer.sv | 159 +++++++++++++++
 tb/tb_tone_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Plays up to DEPTH stored {rest, note, dur} entries on a fixed beat timebase,
// closing every note with GAP_CYCLES of silence so repeated notes stay distinct.
module tone_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 500_000,
    parameter int unsigned DEPTH       = 16
) (
    input  logic       i_clk_50m,
    input  logic       i_reset,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_addr,
    input  logic [2:0] i_wr_note,
    input  logic       i_wr_rest,
    input  logic [3:0] i_wr_dur,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_loop,
    output logic [2:0] o_note_sel,
    output logic       o_tone_en,
    output logic       o_busy,
    output logic [3:0] o_step_idx,
    output logic       o_done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

    localparam logic [31:0] LP_BEAT = 32'(BEAT_CYCLES);
    localparam logic [31:0] LP_GAP  = 32'(GAP_CYCLES);
    localparam logic [3:0]  LP_LAST = 4'(DEPTH - 1);

    logic [7:0]  r_mem [DEPTH];
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] r_len;
    logic        r_rest;
    logic [2:0]  r_note_sel;
    logic        r_tone_en;
    logic        r_busy;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_latch;
    logic        w_rest_nxt;
    logic        w_tone_nxt;
    logic [7:0]  w_entry;
    logic [3:0]  w_ent_dur;
    logic [31:0] w_play_len;

    always_ff @(posedge i_clk_50m or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= {i_wr_rest, i_wr_note, i_wr_dur};
        end
    end

    always_comb begin
        w_entry     = r_mem[r_idx];
        w_ent_dur   = w_entry[3:0];
        w_play_len  = 32'(w_ent_dur) * LP_BEAT - LP_GAP;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_FETCH: begin
                if (w_ent_dur != 4'd0) begin
                    w_state_nxt = S_PLAY;
                end else if (r_idx != 4'd0 && i_loop) begin
                    w_idx_nxt = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_PLAY: begin
                if (r_cnt == r_len - 32'd1) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == LP_GAP - 32'd1) begin
                    if (r_idx != LP_LAST) begin
                        w_state_nxt = S_FETCH;
                        w_idx_nxt   = r_idx + 4'd1;
                    end else if (i_loop) begin
                        w_state_nxt = S_FETCH;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start or completion.
        if (i_stop) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = r_idx;
            w_done_nxt  = 1'b0;
        end

        w_latch    = (r_state == S_FETCH) && (w_state_nxt == S_PLAY);
        w_rest_nxt = w_latch ? w_entry[7] : r_rest;
        w_tone_nxt = (w_state_nxt == S_PLAY) && !w_rest_nxt;

        if (w_state_nxt != r_state || r_state == S_FETCH || r_state == S_IDLE) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk_50m or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_rest     <= 1'b0;
            r_note_sel <= '0;
            r_tone_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rest    <= w_rest_nxt;
            r_tone_en <= w_tone_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            if (w_latch) begin
                r_len      <= w_play_len;
                r_note_sel <= w_entry[6:4];
            end
        end
    end

    assign o_note_sel = r_note_sel;
    assign o_tone_en  = r_tone_en;
    assign o_busy     = r_busy;
    assign o_step_idx = r_idx;
    assign o_done     = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: slot-position reference model compared every cycle,
// plus directed traces with hand-derived cycle counts.
module tb_tone_sequencer;

    localparam int B = 10;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [2:0] wr_note = '0;
    logic       wr_rest = 1'b0;
    logic [3:0] wr_dur = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [2:0] o_note_sel;
    logic       o_tone_en;
    logic       o_busy;
    logic [3:0] o_step_idx;
    logic       o_done;

    always #5 clk = ~clk;

    tone_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .DEPTH(16)) dut (
        .i_clk_50m (clk),
        .i_reset   (rst),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_note (wr_note),
        .i_wr_rest (wr_rest),
        .i_wr_dur  (wr_dur),
        .i_start   (start),
        .i_stop    (stop),
        .i_loop    (loop),
        .o_note_sel(o_note_sel),
        .o_tone_en (o_tone_en),
        .o_busy    (o_busy),
        .o_step_idx(o_step_idx),
        .o_done    (o_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: position inside the current note slot of 1 + dur*B cycles.
    logic [7:0] m_mem [16];
    bit m_active;
    bit m_done;
    bit m_rest;
    int m_idx;
    int m_pos;
    int m_dur;
    int m_note;

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] e;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_active = 0; m_done = 0; m_rest = 0;
            m_idx = 0; m_pos = 0; m_dur = 0; m_note = 0;
        end else begin
            e = m_mem[m_idx];
            m_done = 0;
            if (stop) begin
                m_active = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1; m_idx = 0; m_pos = 0;
                end
            end else if (m_pos == 0) begin
                if (e[3:0] == 4'd0) begin
                    if (m_idx != 0 && loop) m_idx = 0;
                    else begin m_active = 0; m_done = 1; end
                end else begin
                    m_dur = int'(e[3:0]); m_rest = e[7]; m_note = int'(e[6:4]); m_pos = 1;
                end
            end else if (m_pos == m_dur * B) begin
                m_pos = 0;
                if (m_idx == 15) begin
                    if (loop) m_idx = 0;
                    else begin m_active = 0; m_done = 1; end
                end else begin
                    m_idx++;
                end
            end else begin
                m_pos++;
            end
            if (wr_en) m_mem[wr_addr] = {wr_rest, wr_note, wr_dur};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_busy", int'(o_busy), int'(m_active));
            check("cmp_tone", int'(o_tone_en),
                  int'(m_active && m_pos >= 1 && m_pos <= m_dur * B - G && !m_rest));
            check("cmp_note", int'(o_note_sel), m_note);
            check("cmp_idx", int'(o_step_idx), m_idx);
            check("cmp_done", int'(o_done), int'(m_done));
        end
    end

    logic       t_tone [80];
    logic [2:0] t_note [80];
    logic       t_busy [80];
    logic       t_done [80];
    logic [3:0] t_idx  [80];

    task automatic record(input int k);
        t_tone[k] = o_tone_en; t_note[k] = o_note_sel; t_busy[k] = o_busy;
        t_done[k] = o_done;    t_idx[k]  = o_step_idx;
    endtask

    // k = 1 is the cycle after the edge that samples start.
    task automatic start_and_trace(input int n);
        @(negedge clk); start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk); start = 1'b0;
            record(k);
        end
    endtask

    function automatic int count_tone(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (t_tone[k]) c++;
        return c;
    endfunction

    function automatic int count_done(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (t_done[k]) c++;
        return c;
    endfunction

    task automatic write_entry(input int a, input bit r, input int note, input int dur);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(a); wr_rest = r; wr_note = 3'(note); wr_dur = 4'(dur);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_tone_high(input string name);
        for (int k = 0; k < 100 && !o_tone_en; k++) @(negedge clk);
        check(name, int'(o_tone_en), 1);
    endtask

    task automatic load_basic();
        write_entry(0, 0, 2, 2);
        write_entry(1, 0, 5, 1);
        write_entry(2, 0, 0, 0);
    endtask

    initial begin
        int q[$];
        int busy_cnt;
        int max_idx;
        int done_seen;
        logic [3:0] idx_before;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(o_busy), 0);
        check("rst_tone", int'(o_tone_en), 0);
        check("rst_idx", int'(o_step_idx), 0);

        // Basic sequence
        load_basic();
        loop = 1'b0;
        start_and_trace(40);
        check("basic_fetch_busy", int'(t_busy[1]), 1);
        check("basic_fetch_tone", int'(t_tone[1]), 0);
        check("basic_n0_high", count_tone(2, 19), 18);
        check("basic_n0_note", int'(t_note[10]), 2);
        check("basic_gap0_low", count_tone(20, 22), 0);
        check("basic_n1_high", count_tone(23, 30), 8);
        check("basic_n1_note", int'(t_note[25]), 5);
        check("basic_tail_low", count_tone(31, 34), 0);
        check("basic_busy_end", int'(t_busy[33]), 1);
        check("basic_done", int'(t_done[34]), 1);
        check("basic_done_busy", int'(t_busy[34]), 0);
        check("basic_done_idx", int'(t_idx[34]), 2);
        check("basic_done_once", count_done(1, 40), 1);

        // Asynchronous reset mid-PLAY
        start_and_trace(5);
        check("pre_rst_tone", int'(t_tone[5]), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_tone", int'(o_tone_en), 0);
        check("arst_busy", int'(o_busy), 0);
        check("arst_note", int'(o_note_sel), 0);
        check("arst_idx", int'(o_step_idx), 0);
        check("arst_done", int'(o_done), 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(o_busy), 0);
        start_and_trace(4);
        check("memclr_fetch", int'(t_busy[1]), 1);
        check("memclr_done", int'(t_done[2]), 1);
        check("memclr_idle", int'(t_busy[2]), 0);

        // Loop and stop
        load_basic();
        loop = 1'b1;
        start_and_trace(70);
        q.push_back(int'(t_idx[1]));
        for (int k = 2; k <= 70; k++) if (t_idx[k] != t_idx[k-1]) q.push_back(int'(t_idx[k]));
        check("loop_nseq", (q.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < q.size(); i++) check("loop_seq", q[i], i % 3);
        check("loop_no_done", count_done(1, 70), 0);
        wait_tone_high("loop_wait_tone");
        pulse_stop();
        check("stop_tone", int'(o_tone_en), 0);
        check("stop_busy", int'(o_busy), 0);
        check("stop_done", int'(o_done), 0);
        @(negedge clk);
        check("stop_done2", int'(o_done), 0);
        loop = 1'b0;

        // Rest entry
        write_entry(0, 1, 3, 1);
        write_entry(1, 0, 0, 1);
        write_entry(2, 0, 0, 0);
        start_and_trace(30);
        check("rest_silent", count_tone(1, 12), 0);
        check("rest_next_tone", int'(t_tone[13]), 1);
        check("rest_next_note", int'(t_note[13]), 0);

        // Empty sequence with loop set
        write_entry(0, 0, 4, 0);
        loop = 1'b1;
        start_and_trace(6);
        check("empty_fetch", int'(t_busy[1]), 1);
        check("empty_done", int'(t_done[2]), 1);
        check("empty_idle", int'(t_busy[2]), 0);
        check("empty_done_once", count_done(1, 6), 1);
        loop = 1'b0;

        // Full 16-entry pass
        for (int a = 0; a < 16; a++) write_entry(a, 0, a % 8, 1);
        @(negedge clk); start = 1'b1;
        busy_cnt = 0; max_idx = 0; done_seen = 0;
        for (int k = 0; k < 400 && done_seen == 0; k++) begin
            @(negedge clk); start = 1'b0;
            if (o_busy) busy_cnt++;
            if (int'(o_step_idx) > max_idx) max_idx = int'(o_step_idx);
            if (o_done) done_seen = 1;
        end
        check("wrap_done_seen", done_seen, 1);
        check("wrap_busy_cycles", busy_cnt, 16 * 11);
        check("wrap_max_idx", max_idx, 15);

        // start and stop together from IDLE
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("startstop_idle", int'(o_busy), 0);
        @(negedge clk);
        check("startstop_idle2", int'(o_busy), 0);

        // start while busy, and rewriting the playing entry
        load_basic();
        loop = 1'b1;
        @(negedge clk); start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 7) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_rest = 1'b0; wr_note = 3'd7; wr_dur = 4'd1;
            end else begin
                wr_en = 1'b0;
            end
            record(k);
        end
        idx_before = t_idx[5];
        check("rebusy_idx", int'(t_idx[6]), int'(idx_before));
        check("rebusy_tone", int'(t_tone[6]), 1);
        check("rewr_cur_len", count_tone(2, 19), 18);
        check("rewr_cur_gap", int'(t_tone[20]), 0);
        check("rewr_next_idx", int'(t_idx[35]), 0);
        check("rewr_next_len", count_tone(35, 42), 8);
        check("rewr_next_note", int'(t_note[38]), 7);
        check("rewr_next_gap", int'(t_tone[43]), 0);
        pulse_stop();
        loop = 1'b0;

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 24) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) loop = ~loop;
            wr_en = ($urandom_range(0, 7) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_rest = 1'($urandom_range(0, 3) == 0);
            wr_note = 3'($urandom_range(0, 7));
            wr_dur  = 4'($urandom_range(0, 3));
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        check("final_idle", int'(o_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
